// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_LDR = 1'b1;

  // Ownership state that corresponds to a locking port.
  function automatic arb_state_t ownState(input port_id_t p);
    return (p == PORT_LDR) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signals of the data memory arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [1:0]    lock;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;

  // Requesters plus the memory itself.
  modport master (
    output req, we, lock, addr0, addr1, wdata0, wdata1, DataOut,
    input  gnt, rvalid, rdata0, rdata1, DataAddress, ReadMem, WriteMem, DataIn
  );

  // The arbiter.
  modport slave (
    input  req, we, lock, addr0, addr1, wdata0, wdata1, DataOut,
    output gnt, rvalid, rdata0, rdata1, DataAddress, ReadMem, WriteMem, DataIn
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with bounded locked bursts sharing one data memory
// between the CPU load/store unit (port 0) and the loader (port 1).
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BurstMax = CW'(MAX_BURST);

  arb_state_t    state;
  arb_state_t    nextState;
  port_id_t      prio;
  port_id_t      nextPrio;
  logic [CW-1:0] burstCnt;
  logic [CW-1:0] nextBurst;
  logic [1:0]    gntC;
  logic [1:0]    gntOut;
  port_id_t      owner;
  port_id_t      other;
  port_id_t      arbPrio;
  port_id_t      winner;
  logic          doArb;

  // State, priority pointer and burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= PORT_CPU;
      burstCnt <= '0;
    end else begin
      state    <= nextState;
      prio     <= nextPrio;
      burstCnt <= nextBurst;
    end
  end

  // Grant decision and next ownership; a release falls through to normal arbitration.
  always_comb begin
    nextState = state;
    nextPrio  = prio;
    nextBurst = burstCnt;
    gntC      = 2'b00;
    doArb     = 1'b0;
    arbPrio   = prio;
    winner    = PORT_CPU;
    owner     = (state == OWN1) ? PORT_LDR : PORT_CPU;
    other     = ~owner;

    case (state)
      OWN0, OWN1: begin
        if (bus.req[owner] && bus.lock[owner]) begin
          if (!bus.req[other] || (burstCnt < BurstMax)) begin
            gntC[owner] = 1'b1;
            if (burstCnt < BurstMax) begin
              nextBurst = burstCnt + CW'(1);
            end
          end else begin
            // Fairness limit reached with the other port waiting.
            gntC[other] = 1'b1;
            nextPrio    = owner;
            if (bus.lock[other]) begin
              nextState = ownState(other);
              nextBurst = CW'(1);
            end else begin
              nextState = IDLE;
              nextBurst = '0;
            end
          end
        end else begin
          doArb   = 1'b1;
          arbPrio = other;
        end
      end
      default: doArb = 1'b1;
    endcase

    if (doArb) begin
      nextState = IDLE;
      nextBurst = '0;
      nextPrio  = arbPrio;
      if (bus.req != 2'b00) begin
        winner       = (bus.req == 2'b11) ? arbPrio : port_id_t'(bus.req[1]);
        gntC[winner] = 1'b1;
        nextPrio     = ~winner;
        if (bus.lock[winner]) begin
          nextState = ownState(winner);
          nextBurst = CW'(1);
        end
      end
    end
  end

  // Grant and memory controls, all held at zero during reset.
  always_comb begin
    gntOut          = reset ? 2'b00 : gntC;
    bus.gnt         = gntOut;
    bus.DataAddress = {AW{1'b0}};
    bus.DataIn      = {DW{1'b0}};
    bus.ReadMem     = 1'b0;
    bus.WriteMem    = 1'b0;
    if (gntOut[PORT_LDR]) begin
      bus.DataAddress = bus.addr1;
      bus.DataIn      = bus.wdata1;
      bus.ReadMem     = ~bus.we[PORT_LDR];
      bus.WriteMem    = bus.we[PORT_LDR];
    end else if (gntOut[PORT_CPU]) begin
      bus.DataAddress = bus.addr0;
      bus.DataIn      = bus.wdata0;
      bus.ReadMem     = ~bus.we[PORT_CPU];
      bus.WriteMem    = bus.we[PORT_CPU];
    end
  end

  // Capture read data for the granted port and flag it for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rvalid <= 2'b00;
      bus.rdata0 <= {DW{1'b0}};
      bus.rdata1 <= {DW{1'b0}};
    end else begin
      bus.rvalid <= gntOut & ~bus.we;
      if (gntOut[PORT_CPU] && !bus.we[PORT_CPU]) begin
        bus.rdata0 <= bus.DataOut;
      end
      if (gntOut[PORT_LDR] && !bus.we[PORT_LDR]) begin
        bus.rdata1 <= bus.DataOut;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios then random traffic
// compared against a behavioural model of ownership, fairness and memory contents.
module tb_data_mem_arbiter;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int          MAXB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  data_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-port memory: combinational read, write on the rising edge.
  logic [7:0] mem [256];
  always @(posedge clk) if (bus.WriteMem) mem[bus.DataAddress] <= bus.DataIn;
  assign bus.DataOut = bus.ReadMem ? mem[bus.DataAddress] : 8'h00;

  // Reference model state: owner -1 means nobody holds a lock.
  int         mOwner;
  int         mPrio;
  int         mRun;
  logic [1:0] mRvalid;
  logic [7:0] mRdata0;
  logic [7:0] mRdata1;
  logic [7:0] refMem [256];

  int         checks;
  int         failures;
  logic [1:0] lastGnt;
  logic       lastWr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] wv, input logic [1:0] lk,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic [7:0] a1, input logic [7:0] d1);
    bus.req    = rq;
    bus.we     = wv;
    bus.lock   = lk;
    bus.addr0  = a0;
    bus.wdata0 = d0;
    bus.addr1  = a1;
    bus.wdata1 = d1;
  endtask

  // One clock cycle: predict, compare mid-cycle, advance the model at the edge.
  task automatic tick();
    int         w;
    int         p;
    int         nOwner;
    int         nPrio;
    int         nRun;
    logic [1:0] rq;
    logic [1:0] lk;
    logic [1:0] wv;
    logic [1:0] expG;
    logic [7:0] expA;
    logic [7:0] expD;
    logic       expR;
    logic       expW;

    rq = bus.req;
    lk = bus.lock;
    wv = bus.we;
    w = -1;
    nOwner = -1;
    nPrio = mPrio;
    nRun = 0;
    if (mOwner >= 0 && rq[mOwner] && lk[mOwner]) begin
      if (!rq[1 - mOwner] || mRun < MAXB) begin
        w = mOwner;
        nOwner = mOwner;
        nRun = (mRun < MAXB) ? mRun + 1 : mRun;
      end else begin
        w = 1 - mOwner;
        nPrio = mOwner;
        nOwner = lk[w] ? w : -1;
        nRun = lk[w] ? 1 : 0;
      end
    end else begin
      p = (mOwner >= 0) ? 1 - mOwner : mPrio;
      if (rq == 2'b11) w = p;
      else if (rq == 2'b01) w = 0;
      else if (rq == 2'b10) w = 1;
      nPrio = (w >= 0) ? 1 - w : p;
      if (w >= 0 && lk[w]) begin
        nOwner = w;
        nRun = 1;
      end
    end
    if (reset) w = -1;

    expG = 2'b00;
    expA = 8'h00;
    expD = 8'h00;
    expR = 1'b0;
    expW = 1'b0;
    if (w >= 0) begin
      expG[w] = 1'b1;
      expA = (w == 1) ? bus.addr1 : bus.addr0;
      expD = (w == 1) ? bus.wdata1 : bus.wdata0;
      expW = wv[w];
      expR = ~wv[w];
    end

    #2;
    lastGnt = bus.gnt;
    lastWr  = bus.WriteMem;
    chk("gnt", 32'(bus.gnt), 32'(expG));
    chk("DataAddress", 32'(bus.DataAddress), 32'(expA));
    chk("DataIn", 32'(bus.DataIn), 32'(expD));
    chk("ReadMem", 32'(bus.ReadMem), 32'(expR));
    chk("WriteMem", 32'(bus.WriteMem), 32'(expW));
    chk("rd_wr_exclusive", 32'(bus.ReadMem & bus.WriteMem), 32'(0));
    chk("rvalid", 32'(bus.rvalid), 32'(mRvalid));
    chk("rdata0", 32'(bus.rdata0), 32'(mRdata0));
    chk("rdata1", 32'(bus.rdata1), 32'(mRdata1));

    @(posedge clk);
    if (reset) begin
      mOwner = -1;
      mPrio = 0;
      mRun = 0;
      mRvalid = 2'b00;
      mRdata0 = 8'h00;
      mRdata1 = 8'h00;
    end else begin
      mOwner = nOwner;
      mPrio = nPrio;
      mRun = nRun;
      mRvalid = 2'b00;
      if (w >= 0) begin
        if (!wv[w]) begin
          mRvalid[w] = 1'b1;
          if (w == 0) mRdata0 = refMem[expA];
          else mRdata1 = refMem[expA];
        end else begin
          refMem[expA] = expD;
        end
      end
    end
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mOwner = -1;
    mPrio = 0;
    mRun = 0;
    mRvalid = 2'b00;
    mRdata0 = 8'h00;
    mRdata1 = 8'h00;
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;

    // Reset with both ports requesting: nothing may be granted.
    reset = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 8'h01, 8'h11, 8'h02, 8'h22);
    @(posedge clk);
    #1;
    tick();
    chk("reset_gnt", 32'(lastGnt), 32'(0));
    chk("reset_write", 32'(lastWr), 32'(0));
    reset = 1'b0;

    // Write 0xA5 to 0x10 from port 0, read it back.
    drive(2'b01, 2'b01, 2'b00, 8'h10, 8'hA5, 8'h00, 8'h00);
    tick();
    chk("t1_write_gnt", 32'(lastGnt), 32'(2'b01));
    chk("t1_write_mem", 32'(lastWr), 32'(1));
    drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    tick();
    chk("t1_read_gnt", 32'(lastGnt), 32'(2'b01));
    chk("t1_rvalid", 32'(bus.rvalid), 32'(2'b01));
    chk("t1_rdata0", 32'(bus.rdata0), 32'(8'hA5));
    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    // Loader preloads the random-traffic address window.
    for (int a = 0; a < 16; a++) begin
      drive(2'b10, 2'b10, 2'b00, 8'h00, 8'h00, 8'(8'h20 + a), 8'($urandom));
      tick();
    end

    // From reset, two continuous readers alternate.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 2'b00, 8'(8'h20 + k), 8'h00, 8'(8'h28 + k), 8'h00);
      tick();
      chk("alt_gnt", 32'(lastGnt), (k % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      chk("alt_rvalid", 32'(bus.rvalid), (k % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
    end

    // Port 1 locked burst against a waiting port 0: four grants then forced release.
    drive(2'b10, 2'b00, 2'b10, 8'h21, 8'h00, 8'h22, 8'h00);
    tick();
    chk("burst1_gnt0", 32'(lastGnt), 32'(2'b10));
    for (int k = 1; k < 5; k++) begin
      drive(2'b11, 2'b00, 2'b10, 8'h21, 8'h00, 8'(8'h22 + k), 8'h00);
      tick();
      chk("burst1_gnt", 32'(lastGnt), (k < 4) ? 32'(2'b10) : 32'(2'b01));
    end

    // Port 0 locked burst with port 1 idle never releases.
    for (int k = 0; k < 6; k++) begin
      drive(2'b01, 2'b00, 2'b01, 8'(8'h20 + k), 8'h00, 8'h00, 8'h00);
      tick();
      chk("burst0_gnt", 32'(lastGnt), 32'(2'b01));
    end
    drive(2'b01, 2'b00, 2'b00, 8'h27, 8'h00, 8'h00, 8'h00);
    tick();
    chk("burst0_release_gnt", 32'(lastGnt), 32'(2'b01));
    drive(2'b11, 2'b00, 2'b00, 8'h27, 8'h00, 8'h2A, 8'h00);
    tick();
    chk("prio_after_release", 32'(lastGnt), 32'(2'b10));

    // Reset in the second cycle of a locked port-1 write burst.
    drive(2'b10, 2'b10, 2'b10, 8'h00, 8'h00, 8'h2B, 8'h5C);
    tick();
    chk("midreset_first_gnt", 32'(lastGnt), 32'(2'b10));
    reset = 1'b1;
    drive(2'b10, 2'b10, 2'b10, 8'h00, 8'h00, 8'h2C, 8'h6D);
    tick();
    chk("midreset_gnt", 32'(lastGnt), 32'(0));
    chk("midreset_write", 32'(lastWr), 32'(0));
    reset = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 8'h2C, 8'h00, 8'h2D, 8'h00);
    tick();
    chk("midreset_next_gnt", 32'(lastGnt), 32'(2'b01));

    // Random traffic with occasional reset.
    for (int i = 0; i < 10000; i++) begin
      reset = ($urandom_range(199) == 0);
      drive({1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0)},
            2'($urandom), 2'($urandom),
            8'(8'h20 + $urandom_range(15)), 8'($urandom),
            8'(8'h20 + $urandom_range(15)), 8'($urandom));
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port data memory (`data_mem`, combinational read, write on `posedge clk`) between the CPU load/store unit (port 0) and the program/data loader (port 1). Chooses one requester per cycle with round-robin priority and supports locked bursts bounded by a fairness limit. Drives the memory's address, read enable, write enable and write data, and returns registered read data to the granted port.

## Interface
- `AW`, 8, address width (matches `data_mem`)
- `DW`, 8, data width (matches `data_mem`)
- `MAX_BURST`, 4, max consecutive locked grants while the other port waits; must be ≥1

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `req[1:0]`  in  2  per-port access request, level, held until granted
- `we[1:0]`  in  2  per-port write (1) / read (0), valid with `req`
- `lock[1:0]`  in  2  per-port request to keep ownership after the current grant
- `addr0`, `addr1`  in  AW  per-port address
- `wdata0`, `wdata1`  in  DW  per-port write data
- `gnt[1:0]`  out  2  one-hot or zero; access performed this cycle
- `rvalid[1:0]`  out  2  read data valid for that port, one cycle after a read grant
- `rdata0`, `rdata1`  out  DW  per-port captured read data, held until next read by that port
- `DataAddress`  out  AW  to memory
- `ReadMem`, `WriteMem`  out  1  to memory; never both high
- `DataIn`  out  DW  to memory
- `DataOut`  in  DW  from memory (valid when `ReadMem` high)

## Operation
- States: `IDLE` (no owner), `OWN0`, `OWN1` (port holds lock).
- `IDLE`: if exactly one `req` is high, grant it; if both, grant port `prio`; `prio` then points to the non-granted port. If granted port has `lock` high → `OWNx`, `burst_cnt`=1.
- `OWNx`: port x has absolute priority while `req[x]` is high.
  - `req[x]` & `lock[x]` & (other port idle or `burst_cnt` < `MAX_BURST`): grant x, `burst_cnt`++ (saturating).
  - `lock[x]` low, or `req[x]` low: release to `IDLE` and arbitrate normally this same cycle; `prio` = other port.
  - Other port requesting and `burst_cnt` = `MAX_BURST`: forced release; grant the other port this cycle, next state per its `lock`.
- Granted cycle: `DataAddress`=addr of winner; `ReadMem`=~we, `WriteMem`=we; `DataIn`=winner wdata.
- No grant: `ReadMem`=`WriteMem`=0, `DataAddress`=0, `DataIn`=0.
- Read grant: `DataOut` captured into `rdataX` at the closing edge; `rvalid[X]` high for exactly one cycle after.
- `burst_cnt` width `$clog2(MAX_BURST+1)`; resets to 0 on every return to `IDLE`.

## Timing
- Grant decision combinational from `req`/`we`/`lock` and registered state; `gnt` in the same cycle as the qualifying `req`.
- Write latency: committed at the rising edge ending the grant cycle.
- Read latency: 1 cycle; `rdataX`/`rvalid[X]` valid in cycle N+1 for grant in N.
- Back-to-back grants to one port every cycle permitted; throughput 1 access/cycle.
- Requester must hold `req`/`we`/`addr`/`wdata` stable until it sees `gnt`; deasserting earlier is permitted and cancels cleanly.
- Reset (any cycle, including mid-burst): state `IDLE`, `prio`=0, `burst_cnt`=0, `gnt`=0, `rvalid`=0, `rdata0`=`rdata1`=0; memory controls forced 0 while `reset` is high; a write in the reset cycle is not issued.
- Simultaneous reads and writes from both ports: one serviced, the other waits; no dropped request.

## Structure
- `mem_arb_pkg`: `arb_state_t` enum {`IDLE`,`OWN0`,`OWN1`}, `port_id_t` (1 bit), port constants `PORT_CPU`=0, `PORT_LDR`=1.
- No sub-module; a single flat module (state register, `prio`, `burst_cnt`, two read capture registers, combinational grant/mux).

## Test plan
- Reset then `req`=01, `we0`=1, `addr0`=0x10, `wdata0`=0xA5 → `gnt`=01 same cycle, `WriteMem`=1; subsequent read of 0x10 → `rdata0`=0xA5 with `rvalid`=01 next cycle.
- Both ports read continuously, no lock, from reset → grants alternate 01,10,01,10; `rvalid` follows one cycle later each time.
- Port 1 `lock`=1 with continuous `req`, port 0 requesting, `MAX_BURST`=4 → four `gnt`=10 cycles, then `gnt`=01 (forced release).
- Port 0 locked burst with port 1 idle → `gnt`=01 every cycle beyond 4 cycles, no release; drop `lock` → `IDLE`, `prio`=1.
- Assert `reset` in second cycle of a locked port-1 burst with pending write → no `WriteMem` in reset cycle, all outputs 0, next arbitration favours port 0.
- Never `ReadMem`&`WriteMem`, never `gnt`=11 (assertion over random `req`/`we`/`lock` for 10k cycles).
